// File: rtl/game_pkg.sv
// Shared definitions for the game flow controller.
// Holds the state codes, the event-input bundle, and the layout of the
// 10-bit video word {r[2:0], g[2:0], b[1:0], hs, vs}.
package game_pkg;

  // State codes double as the video source index.
  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_MAZE   = 3'd1,
    ST_BATTLE = 3'd2,
    ST_LOSE   = 3'd3,
    ST_BOSS   = 3'd4,
    ST_WIN    = 3'd5
  } game_state_t;

  localparam int NUM_SRC = 6;
  localparam int VID_W   = 10;

  // Field offsets inside one video word.
  localparam int VS_BIT = 0;
  localparam int HS_BIT = 1;
  localparam int B_LSB  = 2;
  localparam int B_W    = 2;
  localparam int G_LSB  = 4;
  localparam int G_W    = 3;
  localparam int R_LSB  = 7;
  localparam int R_W    = 3;

  // All rising-edge detected event inputs, bundled so they share one
  // previous-cycle register and one discard gate.
  typedef struct packed {
    logic restart;
    logic collide;
    logic battle_win;
    logic battle_dead;
    logic boss_win;
    logic boss_dead;
  } ev_t;

endpackage

// File: rtl/frame_sync_mux.sv
// Video source selector.
// Holds the displayed-source register disp_sel, detects falling edges of
// the registered vs output, and registers the selected 6:1 video word.
// Ports:
//   clk, rst     clock; synchronous active-low reset
//   sel_req      requested source (current game state code)
//   vid_in       six packed video words, index = state code
//   r, g, b      registered colour of the displayed source
//   hs, vs       registered sync of the displayed source
module frame_sync_mux
  import game_pkg::*;
#(
  parameter bit FRAME_SYNC = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               sel_req,
  input  logic [NUM_SRC*VID_W-1:0] vid_in,
  output logic [R_W-1:0]           r,
  output logic [G_W-1:0]           g,
  output logic [B_W-1:0]           b,
  output logic                     hs,
  output logic                     vs
);

  logic [2:0]       disp_sel;
  logic             vs_d;
  logic             vs_fall;
  logic [VID_W-1:0] words [NUM_SRC];
  logic [VID_W-1:0] word;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_words
    assign words[i] = vid_in[i*VID_W +: VID_W];
  end

  // Codes 6/7 only exist for a single clock; show START rather than
  // indexing past the last source.
  always_comb begin
    word = words[ST_START];
    if (disp_sel < 3'(NUM_SRC)) word = words[disp_sel];
  end

  assign vs_fall = vs_d & ~vs;

  always_ff @(posedge clk) begin
    if (!rst) begin
      disp_sel <= ST_START;
      vs_d     <= 1'b0;
      r        <= '0;
      g        <= '0;
      b        <= '0;
      hs       <= 1'b1;
      vs       <= 1'b1;
    end else begin
      vs_d <= vs;
      // A change requested mid-frame stays pending simply because
      // disp_sel is not loaded; at the frame edge the newest state wins.
      if (!FRAME_SYNC || vs_fall) disp_sel <= sel_req;
      r  <= word[R_LSB +: R_W];
      g  <= word[G_LSB +: G_W];
      b  <= word[B_LSB +: B_W];
      hs <= word[HS_BIT];
      vs <= word[VS_BIT];
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game flow controller.
// Sequences START -> MAZE -> BATTLE/BOSS -> WIN/LOSE, counts battle wins,
// unlocks the boss, pulses a reset to the battle/boss sub-blocks on entry,
// and selects the video source for the current state.
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   start_sw                 level, leaves START
//   restart                  rising edge leaves WIN/LOSE
//   enemy_collide            rising edge enters BATTLE from MAZE
//   battle_win/battle_dead   rising edges end a battle
//   boss_win/boss_dead       rising edges end the boss fight
//   vid_in                   six packed video words, index = state code
//   r, g, b, hs, vs          selected, registered video
//   game_state               current state code
//   win_count                battles won (saturating)
//   boss_en                  win_count == WIN_TARGET
//   sub_rst                  active-high reset pulse to sub-blocks
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int WIN_TARGET = 5,
  parameter int CNT_W      = 3,
  parameter int RST_PULSE  = 128,
  parameter int FRAME_SYNC = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_sw,
  input  logic                     restart,
  input  logic                     enemy_collide,
  input  logic                     battle_win,
  input  logic                     battle_dead,
  input  logic                     boss_win,
  input  logic                     boss_dead,
  input  logic [NUM_SRC*VID_W-1:0] vid_in,
  output logic [R_W-1:0]           r,
  output logic [G_W-1:0]           g,
  output logic [B_W-1:0]           b,
  output logic                     hs,
  output logic                     vs,
  output logic [2:0]               game_state,
  output logic [CNT_W-1:0]         win_count,
  output logic                     boss_en,
  output logic                     sub_rst
);

  localparam logic [CNT_W-1:0] TARGET = CNT_W'(WIN_TARGET);
  localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [PW-1:0] PULSE_LOAD = PW'(RST_PULSE - 1);

  game_state_t      state_q, state_d;
  ev_t              ev_in, ev_prev, ev;
  logic [CNT_W-1:0] win_count_d;
  logic             win_inc, win_clr, enter_sub;
  logic [PW-1:0]    pulse_cnt;

  assign ev_in = {restart, enemy_collide, battle_win, battle_dead,
                  boss_win, boss_dead};

  // Edges seen while the sub-blocks are held in reset are consumed
  // (ev_prev still advances) so they cannot fire once the pulse ends.
  assign ev = sub_rst ? '0 : ev_t'(ev_in & ~ev_prev);

  // NOTE: every signal written here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    win_inc = 1'b0;
    win_clr = 1'b0;
    case (state_q)
      ST_START:  if (start_sw) state_d = ST_MAZE;
      ST_MAZE: begin
        if (boss_en)         state_d = ST_BOSS;
        else if (ev.collide) state_d = ST_BATTLE;
      end
      ST_BATTLE: begin
        if (ev.battle_dead) begin
          state_d = ST_LOSE;
        end else if (ev.battle_win) begin
          state_d = ST_MAZE;
          win_inc = 1'b1;
        end
      end
      ST_BOSS: begin
        if (ev.boss_dead)     state_d = ST_LOSE;
        else if (ev.boss_win) state_d = ST_WIN;
      end
      ST_WIN, ST_LOSE: begin
        if (ev.restart) begin
          state_d = ST_START;
          win_clr = 1'b1;
        end
      end
      default:   state_d = ST_START;
    endcase
  end

  always_comb begin
    win_count_d = win_count;
    if (win_clr)                           win_count_d = '0;
    else if (win_inc && win_count != TARGET) win_count_d = win_count + CNT_W'(1);
  end

  assign enter_sub = (state_d != state_q) &&
                     (state_d == ST_BATTLE || state_d == ST_BOSS);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_START;
      win_count <= '0;
      boss_en   <= 1'b0;
      ev_prev   <= '0;
      sub_rst   <= 1'b1;
      pulse_cnt <= '0;
    end else begin
      state_q   <= state_d;
      win_count <= win_count_d;
      boss_en   <= (win_count_d == TARGET);
      ev_prev   <= ev_in;
      // Loaded with RST_PULSE-1 and released on the edge after it reaches
      // zero, giving exactly RST_PULSE high cycles after the entry edge.
      if (enter_sub) begin
        sub_rst   <= 1'b1;
        pulse_cnt <= PULSE_LOAD;
      end else if (sub_rst) begin
        if (pulse_cnt == '0) sub_rst <= 1'b0;
        else                 pulse_cnt <= pulse_cnt - PW'(1);
      end
    end
  end

  assign game_state = state_q;

  frame_sync_mux #(
    .FRAME_SYNC (FRAME_SYNC != 0)
  ) u_mux (
    .clk     (clk),
    .rst     (rst),
    .sel_req (state_q),
    .vid_in  (vid_in),
    .r       (r),
    .g       (g),
    .b       (b),
    .hs      (hs),
    .vs      (vs)
  );

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: a vector table for the state/count
// flow plus hand sequences for video switching and reset mid-pulse.
// A second instance with FRAME_SYNC=0 shares all inputs.
module tb_game_flow_ctrl;

  logic        clk, rst;
  logic        start_sw, restart, enemy_collide;
  logic        battle_win, battle_dead, boss_win, boss_dead;
  logic [59:0] vid_in;

  logic [2:0] r, g, r0, g0;
  logic [1:0] b, b0;
  logic       hs, vs, hs0, vs0;
  logic [2:0] game_state, game_state0;
  logic [2:0] win_count, win_count0;
  logic       boss_en, sub_rst, boss_en0, sub_rst0;

  int tests  = 0;
  int failed = 0;

  game_flow_ctrl dut (
    .clk(clk), .rst(rst), .start_sw(start_sw), .restart(restart),
    .enemy_collide(enemy_collide), .battle_win(battle_win),
    .battle_dead(battle_dead), .boss_win(boss_win), .boss_dead(boss_dead),
    .vid_in(vid_in), .r(r), .g(g), .b(b), .hs(hs), .vs(vs),
    .game_state(game_state), .win_count(win_count), .boss_en(boss_en),
    .sub_rst(sub_rst)
  );

  game_flow_ctrl #(.FRAME_SYNC(0)) dut0 (
    .clk(clk), .rst(rst), .start_sw(start_sw), .restart(restart),
    .enemy_collide(enemy_collide), .battle_win(battle_win),
    .battle_dead(battle_dead), .boss_win(boss_win), .boss_dead(boss_dead),
    .vid_in(vid_in), .r(r0), .g(g0), .b(b0), .hs(hs0), .vs(vs0),
    .game_state(game_state0), .win_count(win_count0), .boss_en(boss_en0),
    .sub_rst(sub_rst0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idle;
    logic       s, rs, col, bw, bd, kw, kd;
    logic [2:0] st;
    logic [2:0] cnt;
    logic       be, sr;
  } vec_t;

  vec_t vt[$];

  localparam logic [2:0] S_START = 3'd0, S_MAZE = 3'd1, S_BATTLE = 3'd2,
                         S_LOSE = 3'd3, S_BOSS = 3'd4, S_WIN = 3'd5;

  function automatic vec_t mk(int idle, logic s, logic rs, logic col,
                              logic bw, logic bd, logic kw, logic kd,
                              logic [2:0] st, logic [2:0] cnt,
                              logic be, logic sr);
    vec_t v;
    v.idle = idle; v.s = s; v.rs = rs; v.col = col; v.bw = bw; v.bd = bd;
    v.kw = kw; v.kd = kd; v.st = st; v.cnt = cnt; v.be = be; v.sr = sr;
    return v;
  endfunction

  // Colour of source i as {r,g,b}.
  function automatic logic [7:0] col_of(int i);
    return {3'(i), 3'(7 - i), 2'(i + 1)};
  endfunction

  function automatic logic [59:0] build(logic vs_l);
    logic [59:0] v;
    v = '0;
    for (int i = 0; i < 6; i++) v[i*10 +: 10] = {col_of(i), 1'b1, vs_l};
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic s, logic rs, logic col, logic bw, logic bd,
                       logic kw, logic kd);
    start_sw = s; restart = rs; enemy_collide = col;
    battle_win = bw; battle_dead = bd; boss_win = kw; boss_dead = kd;
  endtask

  // One clock, then sample 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1: idle cycles with all inputs low, then one
  // cycle with the row's inputs, then compare.
  task automatic apply(vec_t v, string tag);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (v.idle) cyc();
    drive(v.s, v.rs, v.col, v.bw, v.bd, v.kw, v.kd);
    cyc();
    check({tag, " state"},   32'(game_state), 32'(v.st));
    check({tag, " count"},   32'(win_count),  32'(v.cnt));
    check({tag, " boss_en"}, 32'(boss_en),    32'(v.be));
    check({tag, " sub_rst"}, 32'(sub_rst),    32'(v.sr));
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    vid_in = build(1'b1);

    // Reset state.
    cyc();
    cyc();
    check("rst state",   32'(game_state), 0);
    check("rst count",   32'(win_count),  0);
    check("rst boss_en", 32'(boss_en),    0);
    check("rst sub_rst", 32'(sub_rst),    1);
    check("rst rgb",     32'({r, g, b}),  0);
    check("rst hs_vs",   32'({hs, vs}),   3);
    rst = 1'b1;
    cyc();
    check("post-rst sub_rst", 32'(sub_rst),    0);
    check("post-rst state",   32'(game_state), 0);

    // Main flow table.
    vt.push_back(mk(0,   1,0,0,0,0,0,0, S_MAZE,   0, 0, 0));
    vt.push_back(mk(0,   0,0,1,0,0,0,0, S_BATTLE, 0, 0, 1));
    vt.push_back(mk(9,   0,0,0,1,0,0,0, S_BATTLE, 0, 0, 1)); // clock 10: ignored
    vt.push_back(mk(117, 0,0,0,1,0,0,0, S_BATTLE, 0, 0, 0)); // clock 128: last discarded
    vt.push_back(mk(1,   0,0,0,1,0,0,0, S_MAZE,   1, 0, 0)); // clock 130: accepted
    for (int k = 1; k < 5; k++) begin
      vt.push_back(mk(0,   0,0,1,0,0,0,0, S_BATTLE, 3'(k),     0, 1));
      vt.push_back(mk(129, 0,0,0,1,0,0,0, S_MAZE,   3'(k + 1), (k == 4), 0));
    end
    vt.push_back(mk(0,   0,0,0,0,0,0,0, S_BOSS,  5, 1, 1));
    vt.push_back(mk(129, 0,0,0,0,0,1,0, S_WIN,   5, 1, 0));
    vt.push_back(mk(0,   1,0,1,1,1,1,1, S_WIN,   5, 1, 0));
    vt.push_back(mk(1,   0,1,0,0,0,0,0, S_START, 0, 0, 0));
    vt.push_back(mk(0,   1,0,0,0,0,0,0, S_MAZE,  0, 0, 0));
    vt.push_back(mk(0,   0,0,1,0,0,0,0, S_BATTLE,0, 0, 1));
    vt.push_back(mk(129, 0,0,0,1,0,0,0, S_MAZE,  1, 0, 0));
    vt.push_back(mk(0,   0,0,1,0,0,0,0, S_BATTLE,1, 0, 1));
    vt.push_back(mk(129, 0,0,0,1,1,0,0, S_LOSE,  1, 0, 0)); // dead beats win
    vt.push_back(mk(0,   1,0,0,1,0,0,0, S_LOSE,  1, 0, 0));
    vt.push_back(mk(1,   0,1,0,0,0,0,0, S_START, 0, 0, 0));

    foreach (vt[i]) apply(vt[i], $sformatf("row%0d", i));

    // Pulse length on boss-style entry counted cycle by cycle.
    begin
      int hi;
      apply(mk(0, 1,0,0,0,0,0,0, S_MAZE,   0, 0, 0), "pl maze");
      apply(mk(0, 0,0,1,0,0,0,0, S_BATTLE, 0, 0, 1), "pl battle");
      drive(0, 0, 0, 0, 0, 0, 0);
      hi = 1;
      for (int i = 0; i < 200 && sub_rst; i++) begin
        cyc();
        if (sub_rst) hi++;
      end
      check("pulse length", 32'(hi), 128);
      apply(mk(0, 0,0,0,1,0,0,0, S_MAZE, 1, 0, 0), "pl exit");
      apply(mk(0, 0,0,1,0,0,0,0, S_BATTLE, 1, 0, 1), "pl re-battle");
      apply(mk(129, 0,0,0,0,1,0,0, S_LOSE, 1, 0, 0), "pl lose");
      apply(mk(1, 0,1,0,0,0,0,0, S_START, 0, 0, 0), "pl restart");
    end

    // Video switching, START -> MAZE.
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    check("vid fs1 idle",  32'({r, g, b}),    32'(col_of(0)));
    check("vid fs0 idle",  32'({r0, g0, b0}), 32'(col_of(0)));
    start_sw = 1'b1;
    cyc();
    start_sw = 1'b0;
    check("vid state maze", 32'(game_state), 32'(S_MAZE));
    cyc();
    check("vid fs0 +1 old", 32'({r0, g0, b0}), 32'(col_of(0)));
    cyc();
    check("vid fs0 +2 new", 32'({r0, g0, b0}), 32'(col_of(1)));
    check("vid fs1 held",   32'({r, g, b}),    32'(col_of(0)));
    repeat (2) cyc();
    check("vid fs1 mid-frame", 32'({r, g, b}), 32'(col_of(0)));
    vid_in = build(1'b0);
    cyc();
    check("vid fs1 vs low",   32'(vs),         0);
    check("vid fs1 f0 old",   32'({r, g, b}),  32'(col_of(0)));
    cyc();
    check("vid fs1 f1 old",   32'({r, g, b}),  32'(col_of(0)));
    cyc();
    check("vid fs1 f2 new",   32'({r, g, b}),  32'(col_of(1)));
    vid_in = build(1'b1);

    // Reset during an active sub_rst pulse with a nonzero count.
    apply(mk(0,   0,0,1,0,0,0,0, S_BATTLE, 0, 0, 1), "rr battle");
    apply(mk(129, 0,0,0,1,0,0,0, S_MAZE,   1, 0, 0), "rr win");
    apply(mk(0,   0,0,1,0,0,0,0, S_BATTLE, 1, 0, 1), "rr battle2");
    repeat (5) cyc();
    rst = 1'b0;
    cyc();
    check("rr state",   32'(game_state), 0);
    check("rr count",   32'(win_count),  0);
    check("rr boss_en", 32'(boss_en),    0);
    check("rr sub_rst", 32'(sub_rst),    1);
    check("rr rgb",     32'({r, g, b}),  0);
    check("rr hs_vs",   32'({hs, vs}),   3);
    rst = 1'b1;
    cyc();
    check("rr release sub_rst", 32'(sub_rst),    0);
    check("rr release state",   32'(game_state), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter WIN_TARGET, default 5: battle wins required before the boss battle unlocks; must be 1..2^CNT_W-1.
REQ-002 Parameter CNT_W, default 3: width of the win counter.
REQ-003 Parameter RST_PULSE, default 128: sub_rst pulse length in clocks, minimum 1.
REQ-004 Parameter FRAME_SYNC, default 1: 1 = video source changes only at a frame boundary; 0 = source changes on the next clock.
REQ-005 clk  in  1  system/pixel clock; the only clock.
REQ-006 rst  in  1  reset, synchronous and active-low.
REQ-007 start_sw  in  1  level; leaves the start screen.
REQ-008 restart  in  1  level; rising edge returns from WIN/LOSE to START.
REQ-009 enemy_collide  in  1  level from the maze.
REQ-010 battle_win, battle_dead, boss_win, boss_dead  in  1 each  battle and boss result levels.
REQ-011 vid_in  in  60  six packed 10-bit words {r[2:0],g[2:0],b[1:0],hs,vs}; index = state code.
REQ-012 r, g, b  out  3, 3, 2  selected colour.
REQ-013 hs, vs  out  1 each  selected sync.
REQ-014 game_state  out  3  current state code.
REQ-015 win_count  out  CNT_W  battles won.
REQ-016 boss_en  out  1  high when win_count == WIN_TARGET.
REQ-017 sub_rst  out  1  active-high reset to the battle/boss screen sub-blocks.

Function
REQ-018 All inputs are synchronous to clk; each event input is rising-edge detected against its own previous-cycle register, giving one event per edge.
REQ-019 State codes: START=0, MAZE=1, BATTLE=2, LOSE=3, BOSS=4, WIN=5; codes 6 and 7 return to START on the next clock.
REQ-020 START: start_sw high -> MAZE.
REQ-021 MAZE: boss_en high -> BOSS, taking priority over collision; otherwise an enemy_collide edge -> BATTLE.
REQ-022 BATTLE: battle_dead edge -> LOSE; otherwise battle_win edge -> MAZE with win_count+1. When both edges arrive in the same cycle, dead wins and the count is unchanged.
REQ-023 win_count saturates at WIN_TARGET and changes only on the BATTLE->MAZE transition.
REQ-024 BOSS: boss_dead edge -> LOSE; otherwise boss_win edge -> WIN. When both arrive together, the result is LOSE.
REQ-025 WIN/LOSE: a restart edge -> START and clears win_count in the same cycle; all other inputs are ignored.
REQ-026 Entering BATTLE or BOSS asserts sub_rst for exactly RST_PULSE cycles, starting the cycle after the transition. Re-entry during a pulse restarts the count.
REQ-027 Event edges arriving while sub_rst is high are discarded.
REQ-028 Video path: r/g/b/hs/vs are registered copies of vid_in[disp_sel], with 1-clock latency from vid_in.
REQ-029 When FRAME_SYNC=0, disp_sel follows game_state with 1-clock lag.
REQ-030 When FRAME_SYNC=1, disp_sel loads game_state only on the clock after a falling edge of the vs output; a pending change survives further state changes, and the newest state is used.
REQ-031 game_state, win_count and boss_en are registered outputs; none has combinational input-to-output paths.

Reset
REQ-032 While rst is low at a clk edge, the block enters this state: state=START, disp_sel=START, win_count=0, all edge registers=0, r/g/b=0, hs=vs=1, sub_rst=1, pulse counter=0.
REQ-033 On the first clock with rst high, sub_rst=0.
REQ-034 Reset applied mid-battle, mid-pulse or with a frame-sync change pending abandons all activity without emitting residual events.

Structure
REQ-035 Shared package game_pkg holds the state code localparams, video word width (10) and field offsets; the block uses these, not literals.
REQ-036 One sub-module, frame_sync_mux, holds disp_sel, the vs edge detect and the registered 6:1 video mux. The FSM, counters and edge detects stay in game_flow_ctrl.

Verification
REQ-037 Use default parameters. start_sw=1, then 5 cycles of collide edge followed by battle_win edge. Required: win_count 1..5, boss_en=1 after the 5th, and the next MAZE cycle goes to BOSS with sub_rst high for 128 clocks.
REQ-038 In BATTLE, assert battle_win and battle_dead edges in the same clock. Required: state=LOSE, win_count unchanged.
REQ-039 Assert a battle_win edge 10 clocks after entering BATTLE. Required: ignored, state stays BATTLE. The same edge at clock 130 -> MAZE.
REQ-040 With FRAME_SYNC=1, change state mid-frame. Required: r/g/b keep the old source until the clock after the vs falling edge, then show vid_in[new state]. With FRAME_SYNC=0, the switch occurs in 2 clocks.
REQ-041 From WIN with win_count=5, give a restart edge. Required: START and win_count=0. Drive rst low during an active sub_rst pulse. Required: all reset values from REQ-032 next clock, sub_rst=0 one clock after rst rises.
